// File: rtl/datapath_pkg.sv
// Shared datapath constants and types for the destination-steering blocks.
//   NUM_DEST   : number of destinations driven by a demux
//   DATA_W     : default data word width
//   dest_sel_t : destination select code
//   SEL_OUTn   : select codes for each destination
package datapath_pkg;

   localparam int unsigned NUM_DEST = 4;
   localparam int unsigned DATA_W   = 4;
   localparam int unsigned SEL_W    = 2;

   typedef logic [SEL_W-1:0] dest_sel_t;

   localparam dest_sel_t SEL_OUT1 = 2'd0;
   localparam dest_sel_t SEL_OUT2 = 2'd1;
   localparam dest_sel_t SEL_OUT3 = 2'd2;
   localparam dest_sel_t SEL_OUT4 = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// One destination slot: a single-entry holding register with a full flag
// and a wrapping delivered-word counter.
//   clk, rst   : clock, synchronous active-high reset
//   load       : write load_data into the slot this cycle
//   load_data  : word to hold
//   out_ready  : consumer takes the held word this cycle
//   out_valid  : slot holds a valid word
//   out_data   : held word (keeps its value after a drain)
//   cnt        : number of words drained, modulo 2^CNT_W
module demux_slot #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] cnt
);

   logic drain;

   always_comb drain = out_valid & out_ready;

   // A load wins over a drain, so load+drain reloads and keeps the slot full.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         cnt       <= '0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
         if (drain) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes. The source
// word is steered by signal into one of four single-entry slots.
//   clk, rst      : clock, synchronous active-high reset
//   InSignal      : source data word
//   signal        : destination select (0..3 -> OutSignal1..OutSignal4)
//   in_valid      : source word and select are valid
//   in_ready      : word is accepted this cycle (combinational)
//   OutSignal1..4 : held destination words
//   out_valid     : per-destination valid
//   out_ready     : per-destination consume
//   count         : packed per-destination delivered-word counters
module demux4_reg
   import datapath_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      InSignal,
   input  dest_sel_t             signal,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      OutSignal1,
   output logic [WIDTH-1:0]      OutSignal2,
   output logic [WIDTH-1:0]      OutSignal3,
   output logic [WIDTH-1:0]      OutSignal4,
   output logic [NUM_DEST-1:0]   out_valid,
   input  logic [NUM_DEST-1:0]   out_ready,
   output logic [NUM_DEST*CNT_W-1:0] count
);

   logic [NUM_DEST-1:0] full;
   logic [NUM_DEST-1:0] load;
   logic [WIDTH-1:0]    data [NUM_DEST];
   logic [CNT_W-1:0]    cnt  [NUM_DEST];
   logic                accept;

   // Selected slot can take a word if empty or draining this cycle.
   always_comb begin
      in_ready = ~rst & (~full[signal] | out_ready[signal]);
      accept   = in_valid & in_ready;
   end

   // One-hot load enable for the selected slot.
   always_comb begin
      load = '0;
      for (int i = 0; i < int'(NUM_DEST); i++) begin
         if (signal == dest_sel_t'(i)) begin
            load[i] = accept;
         end
      end
   end

   for (genvar g = 0; g < int'(NUM_DEST); g++) begin : g_slot
      demux_slot #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .load      (load[g]),
         .load_data (InSignal),
         .out_ready (out_ready[g]),
         .out_valid (full[g]),
         .out_data  (data[g]),
         .cnt       (cnt[g])
      );
      assign count[g*CNT_W +: CNT_W] = cnt[g];
   end

   assign out_valid  = full;
   assign OutSignal1 = data[0];
   assign OutSignal2 = data[1];
   assign OutSignal3 = data[2];
   assign OutSignal4 = data[3];

   // A stalled source must keep its word and select until accepted.
   a_src_hold: assert property (@(posedge clk) disable iff (rst)
      (in_valid && !in_ready) |=> (in_valid && $stable(InSignal) && $stable(signal)));

endmodule
